// File: rtl/picomips_mc.sv
// picomips_mc: multi-cycle picoMIPS core with internal register file, shift-add MULH unit
// and valid/ready handshakes on the input and output ports.
module picomips_mc #(
  parameter int N     = 8,
  parameter int RBITS = 3,
  parameter int PSIZE = 6,
  localparam int ISIZE = 6 + 2 * RBITS + N
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic [PSIZE-1:0] pc_addr_o,
  input  logic [ISIZE-1:0] instr_i,
  input  logic [N-1:0]     in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [N-1:0]     out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             halted_o,
  output logic [2:0]       dbg_state_o
);

  // Handshakes: a word moves on any rising edge where valid && ready are both high.
  // in_ready is high only in S_WAIT_IN; out_valid/out_data are held until accepted.

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_MUL, S_WAIT_IN, S_WAIT_OUT, S_HALT
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_ADDI  = 6'h02;
  localparam logic [5:0] OP_SUB   = 6'h03;
  localparam logic [5:0] OP_MULH  = 6'h04;
  localparam logic [5:0] OP_MULHI = 6'h05;
  localparam logic [5:0] OP_IN    = 6'h06;
  localparam logic [5:0] OP_OUT   = 6'h07;
  localparam logic [5:0] OP_BEQ   = 6'h08;
  localparam logic [5:0] OP_J     = 6'h09;
  localparam logic [5:0] OP_HALT  = 6'h0A;

  localparam int CW = $clog2(N + 1);

  state_t             state_q;
  logic [PSIZE-1:0]   pc_q;
  logic [N-1:0]       regs_q [2**RBITS];
  logic [N-1:0]       out_data_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               halted_q;
  logic [N-1:0]       mcand_q;
  logic [2*N-1:0]     prod_q;
  logic [CW-1:0]      cnt_q;
  logic [RBITS-1:0]   rd_q;

  logic [5:0]         op;
  logic [RBITS-1:0]   rd;
  logic [RBITS-1:0]   rs;
  logic [N-1:0]       imm;
  logic [N-1:0]       rd_val;
  logic [N-1:0]       rs_val;
  logic [PSIZE-1:0]   pc_inc_d;
  logic [N-1:0]       addend_d;
  logic [N:0]         sum_d;
  logic [2*N-1:0]     prod_d;

  assign op     = instr_i[ISIZE-1 -: 6];
  assign rd     = instr_i[N+2*RBITS-1 -: RBITS];
  assign rs     = instr_i[N+RBITS-1 -: RBITS];
  assign imm    = instr_i[N-1:0];
  assign rd_val = regs_q[rd];
  assign rs_val = regs_q[rs];

  assign pc_inc_d = pc_q + 1'b1;

  // One shift-add step: add multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole product right. After N steps prod holds the full 2N-bit product.
  assign addend_d = prod_q[0] ? mcand_q : '0;
  assign sum_d    = {1'b0, prod_q[2*N-1:N]} + {1'b0, addend_d};
  assign prod_d   = {sum_d, prod_q[N-1:1]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      for (int i = 0; i < 2**RBITS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_EXEC;
        S_EXEC: begin
          case (op)
            OP_ADD: begin
              regs_q[rd] <= rd_val + rs_val;
              pc_q       <= pc_inc_d;
              state_q    <= S_FETCH;
            end
            OP_ADDI: begin
              regs_q[rd] <= rd_val + imm;
              pc_q       <= pc_inc_d;
              state_q    <= S_FETCH;
            end
            OP_SUB: begin
              regs_q[rd] <= rd_val - rs_val;
              pc_q       <= pc_inc_d;
              state_q    <= S_FETCH;
            end
            OP_MULH, OP_MULHI: begin
              mcand_q <= rd_val;
              prod_q  <= {{N{1'b0}}, (op == OP_MULH) ? rs_val : imm};
              cnt_q   <= CW'(N);
              rd_q    <= rd;
              state_q <= S_MUL;
            end
            OP_IN: begin
              rd_q       <= rd;
              in_ready_q <= 1'b1;
              state_q    <= S_WAIT_IN;
            end
            OP_OUT: begin
              out_data_q  <= rd_val;
              out_valid_q <= 1'b1;
              state_q     <= S_WAIT_OUT;
            end
            OP_BEQ: begin
              pc_q    <= (rd_val == rs_val) ? imm[PSIZE-1:0] : pc_inc_d;
              state_q <= S_FETCH;
            end
            OP_J: begin
              pc_q    <= imm[PSIZE-1:0];
              state_q <= S_FETCH;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: begin
              pc_q    <= pc_inc_d;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            regs_q[rd_q] <= prod_d[2*N-1:N];
            pc_q         <= pc_inc_d;
            state_q      <= S_FETCH;
          end
        end
        S_WAIT_IN: begin
          if (in_valid_i) begin
            regs_q[rd_q] <= in_data_i;
            in_ready_q   <= 1'b0;
            pc_q         <= pc_inc_d;
            state_q      <= S_FETCH;
          end
        end
        S_WAIT_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_inc_d;
            state_q     <= S_FETCH;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign pc_addr_o   = pc_q;
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign halted_o    = halted_q;
  assign dbg_state_o = 3'(state_q);

endmodule

// File: tb/tb_picomips_mc.sv
// tb_picomips_mc: directed cycle-accurate scenarios plus random programs checked against an
// instruction-level model of the ISA.
module tb_picomips_mc;
  localparam int N = 8, RBITS = 3, PSIZE = 6, ISIZE = 6 + 2 * RBITS + N;

  localparam logic [5:0] OP_NOP = 6'h00, OP_ADD = 6'h01, OP_ADDI = 6'h02, OP_SUB = 6'h03;
  localparam logic [5:0] OP_MULH = 6'h04, OP_MULHI = 6'h05, OP_IN = 6'h06, OP_OUT = 6'h07;
  localparam logic [5:0] OP_BEQ = 6'h08, OP_J = 6'h09, OP_HALT = 6'h0A, OP_BAD = 6'h2A;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [PSIZE-1:0] pc_addr_o;
  logic [ISIZE-1:0] instr_i = '0;
  logic [N-1:0]     in_data_i = '0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [N-1:0]     out_data_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic             halted_o;
  logic [2:0]       dbg_state_o;

  logic [ISIZE-1:0] rom [64];
  logic [N-1:0]     in_words [64];
  logic [N-1:0]     exp_q [$];
  int               exp_in;
  int               n_checks = 0;
  int               n_fails = 0;
  int               cur = 0;

  picomips_mc #(.N(N), .RBITS(RBITS), .PSIZE(PSIZE)) dut (
    .clk_i(clk), .reset_i(reset), .pc_addr_o(pc_addr_o), .instr_i(instr_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .halted_o(halted_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and synchronous program ROM
  always #5 clk = ~clk;
  always @(posedge clk) instr_i <= rom[pc_addr_o];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ISIZE-1:0] enc(logic [5:0] op, int rd, int rs, int imm);
    return {op, rd[2:0], rs[2:0], imm[7:0]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = '0;
  endtask

  // Leaves the bench at the sampling point (falling edge) of cycle 0 after reset release.
  task automatic reset_dut();
    reset = 1'b1;
    in_valid_i = 1'b0;
    in_data_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    cur = 0;
  endtask

  task automatic goto_cycle(int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  // Instruction-level reference: executes the program directly from the ISA rules.
  task automatic run_model();
    int regs [8];
    int pc, steps, op, rd, rs, imm, in_i;
    bit done;
    for (int r = 0; r < 8; r++) regs[r] = 0;
    pc = 0; steps = 0; in_i = 0; done = 0;
    exp_q.delete();
    while (!done && steps < 1000) begin
      op  = int'(rom[pc][19:14]);
      rd  = int'(rom[pc][13:11]);
      rs  = int'(rom[pc][10:8]);
      imm = int'(rom[pc][7:0]);
      steps++;
      case (op)
        1:  begin regs[rd] = (regs[rd] + regs[rs]) % 256; pc = (pc + 1) % 64; end
        2:  begin regs[rd] = (regs[rd] + imm) % 256; pc = (pc + 1) % 64; end
        3:  begin regs[rd] = (regs[rd] - regs[rs] + 256) % 256; pc = (pc + 1) % 64; end
        4:  begin regs[rd] = (regs[rd] * regs[rs]) / 256; pc = (pc + 1) % 64; end
        5:  begin regs[rd] = (regs[rd] * imm) / 256; pc = (pc + 1) % 64; end
        6:  begin regs[rd] = int'(in_words[in_i]); in_i++; pc = (pc + 1) % 64; end
        7:  begin exp_q.push_back(8'(regs[rd])); pc = (pc + 1) % 64; end
        8:  pc = (regs[rd] == regs[rs]) ? imm % 64 : (pc + 1) % 64;
        9:  pc = imm % 64;
        10: done = 1;
        default: pc = (pc + 1) % 64;
      endcase
    end
    exp_in = in_i;
  endtask

  initial begin
    logic [N-1:0] exp_word;
    int dut_in, sel, rd, rs, imm, len;
    bit done;

    // Reset values while reset is held
    clear_rom();
    @(posedge clk);
    #1;
    check("rst_pc", pc_addr_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_halted", halted_o, 0);

    // 1: ADDI, ADDI, OUT, HALT with out_ready high
    rom[0] = enc(OP_ADDI, 1, 0, 5);
    rom[1] = enc(OP_ADDI, 1, 0, 3);
    rom[2] = enc(OP_OUT, 1, 0, 0);
    rom[3] = enc(OP_HALT, 0, 0, 0);
    out_ready_i = 1'b1;
    reset_dut();
    check("t1_pc0", pc_addr_o, 0);
    goto_cycle(4); check("t1_pc4", pc_addr_o, 2);
    goto_cycle(5); check("t1_oval5", out_valid_o, 0);
    goto_cycle(6); check("t1_oval6", out_valid_o, 1); check("t1_odata6", out_data_o, 8'h08);
    goto_cycle(8); check("t1_halt8", halted_o, 0);
    goto_cycle(9); check("t1_halt9", halted_o, 1); check("t1_pc9", pc_addr_o, 3);
    goto_cycle(13); check("t1_pc_frozen", pc_addr_o, 3); check("t1_halt13", halted_o, 1);

    // 2: MULHI timing and result
    clear_rom();
    rom[0] = enc(OP_ADDI, 1, 0, 8'h80);
    rom[1] = enc(OP_MULHI, 1, 0, 8'h80);
    rom[2] = enc(OP_OUT, 1, 0, 0);
    rom[3] = enc(OP_HALT, 0, 0, 0);
    reset_dut();
    goto_cycle(2); check("t2_pc_mul_fetch", pc_addr_o, 1);
    goto_cycle(11); check("t2_pc_mul_busy", pc_addr_o, 1);
    goto_cycle(12); check("t2_pc_mul_retired", pc_addr_o, 2);
    goto_cycle(14); check("t2_oval", out_valid_o, 1); check("t2_odata", out_data_o, 8'h40);

    // 3 + 4: IN with a delayed producer, then OUT with a delayed consumer
    clear_rom();
    rom[0] = enc(OP_IN, 2, 0, 0);
    rom[1] = enc(OP_OUT, 2, 0, 0);
    rom[2] = enc(OP_HALT, 0, 0, 0);
    out_ready_i = 1'b0;
    reset_dut();
    check("t3_iready0", in_ready_o, 0);
    for (int k = 2; k <= 6; k++) begin
      goto_cycle(k);
      check("t3_iready_wait", in_ready_o, 1);
      check("t3_pc_wait", pc_addr_o, 0);
    end
    @(posedge clk); #1; in_valid_i = 1'b1; in_data_i = 8'hA5;
    goto_cycle(7); check("t3_iready7", in_ready_o, 1);
    @(posedge clk); #1; in_valid_i = 1'b0; in_data_i = 8'h00;
    goto_cycle(8); check("t3_iready8", in_ready_o, 0); check("t3_pc8", pc_addr_o, 1);
    for (int k = 10; k <= 13; k++) begin
      goto_cycle(k);
      check("t4_oval_hold", out_valid_o, 1);
      check("t4_odata_hold", out_data_o, 8'hA5);
      check("t4_pc_hold", pc_addr_o, 1);
    end
    @(posedge clk); #1; out_ready_i = 1'b1;
    goto_cycle(14); check("t4_oval14", out_valid_o, 1); check("t4_pc14", pc_addr_o, 1);
    goto_cycle(15);
    check("t4_oval15", out_valid_o, 0);
    check("t4_odata_kept", out_data_o, 8'hA5);
    check("t4_pc15", pc_addr_o, 2);

    // 5: taken branch to 62, wrap 63 -> 0, untaken branch falls through
    clear_rom();
    rom[0]  = enc(OP_BEQ, 1, 0, 62);
    rom[1]  = enc(OP_HALT, 0, 0, 0);
    rom[62] = enc(OP_ADDI, 1, 0, 1);
    rom[63] = enc(OP_NOP, 0, 0, 0);
    reset_dut();
    goto_cycle(2); check("t5_pc_taken", pc_addr_o, 62);
    goto_cycle(4); check("t5_pc63", pc_addr_o, 63);
    goto_cycle(6); check("t5_pc_wrap", pc_addr_o, 0);
    goto_cycle(8); check("t5_pc_fall", pc_addr_o, 1);
    goto_cycle(10); check("t5_halt", halted_o, 1);

    // 6: asynchronous reset in the third MUL cycle
    clear_rom();
    rom[0] = enc(OP_ADDI, 1, 0, 8'hFF);
    rom[1] = enc(OP_OUT, 1, 0, 0);
    rom[2] = enc(OP_MULHI, 1, 0, 8'hFF);
    rom[3] = enc(OP_OUT, 1, 0, 0);
    rom[4] = enc(OP_HALT, 0, 0, 0);
    out_ready_i = 1'b1;
    reset_dut();
    goto_cycle(4); check("t6_odata_ff", out_data_o, 8'hFF);
    goto_cycle(9); check("t6_pc_mul", pc_addr_o, 2);
    #2 reset = 1'b1;
    #1;
    check("t6_async_pc", pc_addr_o, 0);
    check("t6_async_odata", out_data_o, 0);
    check("t6_async_oval", out_valid_o, 0);
    reset_dut();
    check("t6_pc_release", pc_addr_o, 0);
    goto_cycle(4); check("t6_rerun_first_out", out_data_o, 8'hFF);
    goto_cycle(17); check("t6_oval17", out_valid_o, 1); check("t6_mul_result", out_data_o, 8'hFE);

    // Random programs against the instruction-level model
    for (int p = 0; p < 6; p++) begin
      clear_rom();
      len = 24;
      for (int i = 0; i < 64; i++) in_words[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 10);
        rd  = $urandom_range(0, 7);
        rs  = $urandom_range(0, 7);
        imm = $urandom_range(0, 255);
        case (sel)
          0: rom[i] = enc(OP_NOP, rd, rs, imm);
          1: rom[i] = enc(OP_ADD, rd, rs, imm);
          2: rom[i] = enc(OP_ADDI, rd, rs, imm);
          3: rom[i] = enc(OP_SUB, rd, rs, imm);
          4: rom[i] = enc(OP_MULH, rd, rs, imm);
          5: rom[i] = enc(OP_MULHI, rd, rs, imm);
          6: rom[i] = enc(OP_IN, rd, rs, imm);
          7: rom[i] = enc(OP_OUT, rd, rs, imm);
          8: rom[i] = enc(OP_BEQ, rd, rs, $urandom_range(i + 1, len));
          9: rom[i] = enc(OP_J, rd, rs, $urandom_range(i + 1, len));
          default: rom[i] = enc(OP_BAD, rd, rs, imm);
        endcase
      end
      for (int r = 0; r < 8; r++) rom[len + r] = enc(OP_OUT, r, 0, 0);
      rom[len + 8] = enc(OP_HALT, 0, 0, 0);
      run_model();
      out_ready_i = 1'b0;
      reset_dut();
      dut_in = 0;
      done = 0;
      for (int c = 0; c < 4000 && !done; c++) begin
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) check("rand_out_extra", out_data_o, 32'hFFFF_FFFF);
          else begin
            exp_word = exp_q.pop_front();
            check("rand_out", out_data_o, exp_word);
          end
        end
        if (in_valid_i && in_ready_o) dut_in++;
        if (halted_o) done = 1;
        else begin
          @(posedge clk); #1;
          out_ready_i = 1'($urandom_range(0, 1));
          in_valid_i  = ($urandom_range(0, 3) != 0);
          in_data_i   = in_words[dut_in % 64];
          @(negedge clk);
        end
      end
      check("rand_halted", done, 1);
      check("rand_outs_left", exp_q.size(), 0);
      check("rand_in_count", dut_in, exp_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
